// File: rtl/pio_edge_irq_pkg.sv
// rtl/pio_edge_irq_pkg.sv - register map constants for the edge-capture interrupt PIO
package pio_edge_irq_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd4;

endpackage

// File: rtl/pio_irq_debounce.sv
// rtl/pio_irq_debounce.sv - one input channel: synchroniser chain plus optional debounce filter
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   i_in     raw asynchronous input bit
//   o_filt   synchronised (and, when DEB_CYCLES>0, debounced) level
module pio_irq_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_in,
    output logic o_filt
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        if (DEB_CYCLES == 0) begin : g_bypass
            assign o_filt = w_sync;
        end else begin : g_deb
            localparam int CW = $clog2(DEB_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

            logic [CW-1:0] r_cnt;
            logic          r_filt;

            // The count tracks consecutive samples that disagree with the
            // accepted level; the DEB_CYCLES-th such sample commits the change.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt  <= '0;
                    r_filt <= 1'b0;
                end else if (w_sync != r_filt) begin
                    if (r_cnt == LAST) begin
                        r_filt <= w_sync;
                        r_cnt  <= '0;
                    end else if (r_cnt != {CW{1'b1}}) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign o_filt = r_filt;
        end
    endgenerate

endmodule

// File: rtl/pio_edge_irq.sv
// rtl/pio_edge_irq.sv - multi-channel input PIO with edge capture and masked level interrupt
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address, chipselect   register select (word address)
//   write_n, writedata    active-low write strobe and write data
//   readdata              registered read data, one cycle after address
//   in_port               asynchronous external inputs
//   irq                   level interrupt, high while any unmasked capture bit is set
module pio_edge_irq
    import pio_edge_irq_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               DEB_CYCLES  = 0,
    parameter logic [WIDTH-1:0] RISE_RST    = '1,
    parameter logic [WIDTH-1:0] FALL_RST    = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [WIDTH-1:0]  writedata,
    output logic [WIDTH-1:0]  readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_ev;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rd_mux;
    logic             w_wr;

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_readdata;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            pio_irq_debounce #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEB_CYCLES  (DEB_CYCLES)
            ) u_deb (
                .clk     (clk),
                .reset_n (reset_n),
                .i_in    (in_port[gi]),
                .o_filt  (w_filt[gi])
            );
        end
    endgenerate

    assign w_wr  = chipselect & ~write_n;
    assign w_ev  = (w_filt & ~r_prev & r_rise_en) | (~w_filt & r_prev & r_fall_en);
    assign w_clr = (w_wr && (address == ADDR_EDGE_CAP)) ? writedata : '0;

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:     w_rd_mux = w_filt;
            ADDR_RISE_EN:  w_rd_mux = r_rise_en;
            ADDR_IRQ_MASK: w_rd_mux = r_mask;
            ADDR_EDGE_CAP: w_rd_mux = r_cap;
            ADDR_FALL_EN:  w_rd_mux = r_fall_en;
            default:       w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev     <= '0;
            r_rise_en  <= RISE_RST;
            r_fall_en  <= FALL_RST;
            r_mask     <= '0;
            r_cap      <= '0;
            r_readdata <= '0;
        end else begin
            r_prev     <= w_filt;
            r_readdata <= w_rd_mux;
            // OR-ing the event after the clear lets a same-cycle edge win.
            r_cap      <= (r_cap & ~w_clr) | w_ev;
            if (w_wr) begin
                case (address)
                    ADDR_RISE_EN:  r_rise_en <= writedata;
                    ADDR_IRQ_MASK: r_mask    <= writedata;
                    ADDR_FALL_EN:  r_fall_en <= writedata;
                    default:       ;
                endcase
            end
        end
    end

    assign readdata = r_readdata;
    // Driven only from flops through an AND/OR tree, so no decode glitches.
    assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_pio_edge_irq.sv
// tb/tb_pio_edge_irq.sv - self-checking bench for pio_edge_irq against a delay-line/window model
module tb_pio_edge_irq;

    localparam int S   = 2;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] address;
    logic       chipselect;
    logic       write_n;
    logic [7:0] writedata;
    logic [7:0] in_a, in_d;
    logic [7:0] rd_a, rd_d;
    logic       irq_a, irq_d;

    always #5 clk = ~clk;

    pio_edge_irq #(.WIDTH(8), .SYNC_STAGES(S), .DEB_CYCLES(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in_a), .irq(irq_a)
    );

    pio_edge_irq #(.WIDTH(8), .SYNC_STAGES(S), .DEB_CYCLES(DEB)) dut_d (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_d),
        .in_port(in_d), .irq(irq_d)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: input samples kept as a delay line (index k = sampled k+1 edges ago)
    logic [7:0] smp_a [0:S];
    logic [7:0] smp_d [0:S+DEB-2];
    logic [7:0] m_rise, m_fall, m_mask, m_cap_a, m_cap_d, m_fd, m_pd, m_rd_a, m_rd_d;
    logic       m_irq_a, m_irq_d;

    function automatic logic [7:0] rmux(input logic [2:0] a, input logic [7:0] data,
                                        input logic [7:0] cap);
        case (a)
            3'd0:    return data;
            3'd1:    return m_rise;
            3'd2:    return m_mask;
            3'd3:    return cap;
            3'd4:    return m_fall;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_edge();
        logic [7:0] fa, pa, ev_a, ev_d, clr, nd;
        logic       wr;
        bit         all_diff;
        if (!reset_n) begin
            for (int k = 0; k <= S; k++) smp_a[k] = 8'h00;
            for (int k = 0; k <= S+DEB-2; k++) smp_d[k] = 8'h00;
            m_rise = 8'hFF; m_fall = 8'h00; m_mask = 8'h00;
            m_cap_a = 8'h00; m_cap_d = 8'h00; m_fd = 8'h00; m_pd = 8'h00;
            m_rd_a = 8'h00; m_rd_d = 8'h00;
        end else begin
            // Undebounced level seen now is the sample from S edges ago.
            fa   = smp_a[S-1];
            pa   = smp_a[S];
            ev_a = (fa & ~pa & m_rise) | (~fa & pa & m_fall);
            ev_d = (m_fd & ~m_pd & m_rise) | (~m_fd & m_pd & m_fall);
            wr   = chipselect & ~write_n;
            m_rd_a = rmux(address, fa, m_cap_a);
            m_rd_d = rmux(address, m_fd, m_cap_d);
            clr  = (wr && address == 3'd3) ? writedata : 8'h00;
            m_cap_a = (m_cap_a & ~clr) | ev_a;
            m_cap_d = (m_cap_d & ~clr) | ev_d;
            if (wr) begin
                if (address == 3'd1) m_rise = writedata;
                if (address == 3'd2) m_mask = writedata;
                if (address == 3'd4) m_fall = writedata;
            end
            // Debounced level flips once the last DEB synchronised samples all disagree with it.
            nd = m_fd;
            for (int b = 0; b < 8; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (smp_d[S-1+k][b] == m_fd[b]) all_diff = 1'b0;
                if (all_diff) nd[b] = ~m_fd[b];
            end
            m_pd = m_fd;
            m_fd = nd;
            for (int k = S; k > 0; k--) smp_a[k] = smp_a[k-1];
            smp_a[0] = in_a;
            for (int k = S+DEB-2; k > 0; k--) smp_d[k] = smp_d[k-1];
            smp_d[0] = in_d;
        end
        m_irq_a = |(m_cap_a & m_mask);
        m_irq_d = |(m_cap_d & m_mask);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("rd_a", rd_a, m_rd_a);
        check_eq("rd_d", rd_d, m_rd_d);
        check_eq("irq_a", irq_a, m_irq_a);
        check_eq("irq_d", irq_d, m_irq_d);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a);
        address = a;
        tick();
    endtask

    initial begin
        reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 8'h00; in_a = 8'h00; in_d = 8'h00;

        // Reset with inputs toggling
        for (int i = 0; i < 4; i++) begin
            in_a = 8'($urandom); in_d = 8'($urandom);
            tick();
        end
        check_eq("rst_rd", rd_a, 8'h00);
        check_eq("rst_irq", irq_a, 1'b0);
        in_a = 8'h00; in_d = 8'h00;
        reset_n = 1'b1;
        ticks(3);
        bus_rd(3'd1); check_eq("rst_rise", rd_a, 8'hFF);
        bus_rd(3'd4); check_eq("rst_fall", rd_a, 8'h00);
        bus_rd(3'd2); check_eq("rst_mask", rd_a, 8'h00);

        // Rising edge latency and W1C
        bus_wr(3'd2, 8'h01);
        ticks(2);
        in_a = 8'h01;
        tick(); check_eq("lat1", irq_a, 1'b0);
        tick(); check_eq("lat2", irq_a, 1'b0);
        tick(); check_eq("lat3", irq_a, 1'b1);
        bus_rd(3'd3); check_eq("cap_rise", rd_a, 8'h01);
        bus_wr(3'd3, 8'h01); check_eq("irq_clr", irq_a, 1'b0);

        // Falling-only, then both edges
        in_a = 8'h00; ticks(4);
        bus_wr(3'd1, 8'h00); bus_wr(3'd4, 8'h80); bus_wr(3'd3, 8'hFF);
        in_a = 8'h80; ticks(4);
        bus_rd(3'd3); check_eq("fall_norise", rd_a, 8'h00);
        in_a = 8'h00; ticks(4);
        bus_rd(3'd3); check_eq("fall_cap", rd_a, 8'h80);
        bus_wr(3'd3, 8'hFF); bus_wr(3'd1, 8'h80);
        in_a = 8'h80; ticks(4);
        bus_rd(3'd3); check_eq("any_rise", rd_a, 8'h80);
        bus_wr(3'd3, 8'h80);
        bus_rd(3'd3); check_eq("any_clr", rd_a, 8'h00);
        in_a = 8'h00; ticks(4);
        bus_rd(3'd3); check_eq("any_fall", rd_a, 8'h80);

        // Clear-vs-event race and partial clear
        bus_wr(3'd1, 8'hFF); bus_wr(3'd4, 8'h00); bus_wr(3'd3, 8'hFF);
        in_a = 8'h04;
        ticks(2);
        bus_wr(3'd3, 8'h04);
        bus_rd(3'd3); check_eq("race", rd_a, 8'h04);
        bus_wr(3'd3, 8'hFF);
        in_a = 8'h15; ticks(4);
        bus_rd(3'd3); check_eq("cap_0_4", rd_a, 8'h11);
        bus_wr(3'd3, 8'h0F);
        bus_rd(3'd3); check_eq("w1c_part", rd_a, 8'h10);

        // Mask and readback
        in_a = 8'h00; ticks(4);
        bus_wr(3'd3, 8'hFF);
        in_a = 8'h05; ticks(4);
        bus_wr(3'd2, 8'h04); check_eq("mask_on", irq_a, 1'b1);
        bus_wr(3'd2, 8'h02); check_eq("mask_off", irq_a, 1'b0);
        bus_rd(3'd3); check_eq("cap_kept", rd_a, 8'h05);
        for (int a = 5; a < 8; a++) begin
            bus_rd(3'(a));
            check_eq("unused_a", rd_a, 8'h00);
            check_eq("unused_d", rd_d, 8'h00);
        end

        // Debounce: short glitch, stable level, reset mid-count
        in_d = 8'h01; ticks(3);
        in_d = 8'h00; ticks(8);
        bus_rd(3'd0); check_eq("glitch_data", rd_d, 8'h00);
        bus_rd(3'd3); check_eq("glitch_cap", rd_d, 8'h00);
        in_d = 8'h01; ticks(10);
        bus_rd(3'd0); check_eq("deb_data", rd_d, 8'h01);
        bus_rd(3'd3); check_eq("deb_cap", rd_d, 8'h01);
        reset_n = 1'b0; in_d = 8'h00; tick();
        reset_n = 1'b1; ticks(2);
        in_d = 8'h01; ticks(4);
        reset_n = 1'b0; tick();
        reset_n = 1'b1; ticks(2);
        in_d = 8'h00; ticks(8);
        bus_rd(3'd0); check_eq("deb_rst", rd_d, 8'h00);

        // Randomised traffic
        bus_wr(3'd2, 8'hFF);
        bus_wr(3'd4, 8'($urandom));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) in_a = 8'($urandom);
            if ($urandom_range(0, 5) == 0) in_d = in_d ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                bus_wr(3'($urandom_range(0, 7)), 8'($urandom));
            end else begin
                chipselect = 1'($urandom_range(0, 1));
                bus_rd(3'($urandom_range(0, 7)));
                chipselect = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
